pll_lock_clken: RTL and testbench

Parametrised lock-qualified clock-enable generator, the successor to the single-output PLL wrapper.
- Takes the asynchronous `locked` flag of an external PLL, synchronises and debounces it, and tracks loss-of-lock events.
- Derives NCH phase-aligned clock enables at programmable divide ratios from the single system clock.
- Sits directly behind the PLL; downstream logic runs on CLK and is gated by `clk_en` instead of using extra PLL outputs.

---
 rtl/clken_pkg.sv | 19 +
 rtl/clken_div.sv | 43 ++++
 rtl/pll_lock_clken.sv | 136 +++++++++++++
 tb/tb_pll_lock_clken.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared types and constants for the lock-qualified clock-enable generator.
package clken_pkg;

    // Lock qualification FSM states.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        QUALIFY  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Default number of consecutive synchronised-high cycles to declare lock.
    localparam int DEFAULT_LOCK_STABLE = 1000;

    // Width of the stable counter so it can hold values 0..lock_stable.
    function automatic int stable_cnt_w(input int lock_stable);
        return $clog2(lock_stable + 1);
    endfunction

endpackage

// File: rtl/clken_div.sv
// One clock-enable channel: phase counter, divide compare and registered enable.
// `run` is the lock state for the coming cycle; its registered copy is the
// lock state of the current cycle, which governs counting.
module clken_div #(
    parameter int DIVW = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            run,
    input  logic            realign,
    input  logic [DIVW-1:0] div,
    output logic            en
);

    logic            r_run;
    logic [DIVW-1:0] r_cnt;
    logic            r_en;
    logic [DIVW-1:0] w_cnt_nxt;

    // Next phase: hold 0 when not locked or realigning, wrap on cnt >= div.
    always_comb begin
        w_cnt_nxt = '0;
        if (r_run && !realign && (r_cnt < div)) begin
            w_cnt_nxt = r_cnt + DIVW'(1);
        end
    end

    // Phase register and enable, which is high whenever the coming cycle is locked at phase 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else begin
            r_run <= run;
            r_cnt <= w_cnt_nxt;
            r_en  <= run && (w_cnt_nxt == '0);
        end
    end

    assign en = r_en;

endmodule

// File: rtl/pll_lock_clken.sv
// Lock-qualified clock-enable generator: synchronises and debounces the PLL
// lock flag, tracks lock losses, and drives NCH phase-aligned clock enables.
module pll_lock_clken
    import clken_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DIVW        = 8,
    parameter int LOCK_STABLE = DEFAULT_LOCK_STABLE,
    parameter int LOSTW       = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                pll_locked,
    input  logic [NCH*DIVW-1:0] div,
    input  logic                resync,
    input  logic                clr_lost,
    output logic                locked_q,
    output logic [NCH-1:0]      clk_en,
    output logic [LOSTW-1:0]    lost_cnt,
    output logic                lost_sticky,
    output lock_state_t         o_dbg_state
);

    localparam int SW = stable_cnt_w(LOCK_STABLE);

    logic             r_sync1;
    logic             r_lk_s;
    lock_state_t      r_state;
    logic [SW-1:0]    r_stable_cnt;
    logic             r_locked_q;
    logic [LOSTW-1:0] r_lost_cnt;
    logic             r_lost_sticky;

    logic             w_qual_done;
    logic             w_run_nxt;
    logic             w_realign;
    logic             w_loss;

    // Two-flop synchroniser; the only place pll_locked is sampled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_lk_s  <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_lk_s  <= r_sync1;
        end
    end

    // Last qualifying cycle: this edge brings the count to LOCK_STABLE.
    assign w_qual_done = (r_state == QUALIFY) && (r_stable_cnt == SW'(LOCK_STABLE - 1));
    // Lock state for the coming cycle; feeds the channels so they fire on the first LOCKED cycle.
    assign w_run_nxt   = r_lk_s && ((r_state == LOCKED) || w_qual_done);
    assign w_realign   = resync && (r_state == LOCKED);
    assign w_loss      = (r_state == LOCKED) && !r_lk_s;

    // Lock qualification FSM with registered lock output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= UNLOCKED;
            r_stable_cnt <= '0;
            r_locked_q   <= 1'b0;
        end else begin
            r_locked_q <= w_run_nxt;
            case (r_state)
                UNLOCKED: begin
                    if (r_lk_s) begin
                        r_state      <= QUALIFY;
                        r_stable_cnt <= SW'(1);
                    end else begin
                        r_stable_cnt <= '0;
                    end
                end
                QUALIFY: begin
                    if (!r_lk_s) begin
                        r_state      <= UNLOCKED;
                        r_stable_cnt <= '0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + SW'(1);
                        if (w_qual_done) begin
                            r_state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!r_lk_s) begin
                        r_state      <= UNLOCKED;
                        r_stable_cnt <= '0;
                    end
                end
                default: begin
                    r_state      <= UNLOCKED;
                    r_stable_cnt <= '0;
                end
            endcase
        end
    end

    // Loss-of-lock tracking; a loss on the same edge as clr_lost wins and counts as the first loss.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_lost_cnt    <= '0;
            r_lost_sticky <= 1'b0;
        end else if (w_loss) begin
            r_lost_sticky <= 1'b1;
            if (clr_lost) begin
                r_lost_cnt <= LOSTW'(1);
            end else if (r_lost_cnt != '1) begin
                r_lost_cnt <= r_lost_cnt + LOSTW'(1);
            end
        end else if (clr_lost) begin
            r_lost_cnt    <= '0;
            r_lost_sticky <= 1'b0;
        end
    end

    // One divider per channel, all sharing run/realign so equal ratios have zero skew.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        clken_div #(
            .DIVW(DIVW)
        ) u_div (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .run    (w_run_nxt),
            .realign(w_realign),
            .div    (div[gi*DIVW +: DIVW]),
            .en     (clk_en[gi])
        );
    end

    assign locked_q    = r_locked_q;
    assign lost_cnt    = r_lost_cnt;
    assign lost_sticky = r_lost_sticky;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pll_lock_clken.sv
// Bench for pll_lock_clken: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the lock/enable rules.
module tb_pll_lock_clken;
    import clken_pkg::*;

    localparam int NCH      = 2;
    localparam int DIVW     = 4;
    localparam int LS       = 8;
    localparam int LOSTW    = 2;
    localparam int MAX_LOST = (1 << LOSTW) - 1;

    logic                CLK        = 1'b0;
    logic                RST_N      = 1'b0;
    logic                pll_locked = 1'b0;
    logic                resync     = 1'b0;
    logic                clr_lost   = 1'b0;
    logic [NCH*DIVW-1:0] div        = 8'h30;
    logic                locked_q;
    logic [NCH-1:0]      clk_en;
    logic [LOSTW-1:0]    lost_cnt;
    logic                lost_sticky;
    lock_state_t         dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: raw lock history, run length of seen-high samples,
    // and per-channel timestamp of the last enable pulse.
    bit pll_q[$];
    int m_e;
    int m_run;
    bit m_locked;
    int m_lost;
    bit m_sticky;
    bit [NCH-1:0] m_en;
    int last_fire[NCH];

    pll_lock_clken #(
        .NCH(NCH), .DIVW(DIVW), .LOCK_STABLE(LS), .LOSTW(LOSTW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .pll_locked(pll_locked), .div(div),
        .resync(resync), .clr_lost(clr_lost), .locked_q(locked_q),
        .clk_en(clk_en), .lost_cnt(lost_cnt), .lost_sticky(lost_sticky),
        .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pll_q.delete();
        pll_q.push_back(1'b0);
        pll_q.push_back(1'b0);
        m_run    = 0;
        m_locked = 1'b0;
        m_lost   = 0;
        m_sticky = 1'b0;
        m_en     = '0;
        for (int c = 0; c < NCH; c++) last_fire[c] = -1000;
    endtask

    // Advance the model by one edge using the inputs present before that edge.
    task automatic model_edge();
        bit lk, was, fire;
        int d;
        lk = pll_q.pop_front();
        pll_q.push_back(pll_locked);
        m_e++;
        was = m_locked;
        m_run = lk ? m_run + 1 : 0;
        if (m_run > 10000) m_run = 10000;
        m_locked = (m_run >= LS);
        if (was && !lk) begin
            m_lost = (clr_lost ? 0 : m_lost) + 1;
            if (m_lost > MAX_LOST) m_lost = MAX_LOST;
            m_sticky = 1'b1;
        end else if (clr_lost) begin
            m_lost   = 0;
            m_sticky = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            d = int'(div[c*DIVW +: DIVW]);
            fire = m_locked && (!was || resync || (m_e - last_fire[c] >= d + 1));
            if (fire) last_fire[c] = m_e;
            m_en[c] = fire;
        end
    endtask

    task automatic check_all();
        chk("locked_q", locked_q, m_locked);
        chk("clk_en", clk_en, m_en);
        chk("lost_cnt", lost_cnt, m_lost);
        chk("lost_sticky", lost_sticky, m_sticky);
        chk("dbg_locked", dbg_state == LOCKED, m_locked);
    endtask

    // Driver: apply inputs, take one edge, check all outputs 1ns later.
    task automatic step(input logic pl, input logic rs, input logic cl, input logic [7:0] dv);
        pll_locked = pl;
        resync     = rs;
        clr_lost   = cl;
        div        = dv;
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic do_reset(input string tag);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk({tag, "_locked"}, locked_q, 0);
        chk({tag, "_en"}, clk_en, 0);
        chk({tag, "_lost"}, lost_cnt, 0);
        chk({tag, "_sticky"}, lost_sticky, 0);
        chk({tag, "_state"}, dbg_state, UNLOCKED);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        logic pl;
        int rem;
        logic [7:0] dv;
        m_e = 0;
        model_reset();

        // Reset values
        #12;
        chk("rst_locked", locked_q, 0);
        chk("rst_en", clk_en, 0);
        chk("rst_lost", lost_cnt, 0);
        chk("rst_sticky", lost_sticky, 0);
        chk("rst_state", dbg_state, UNLOCKED);
        RST_N = 1'b1;

        // 1: acquisition at edge 9, ch0 constant, ch1 every 4
        for (int k = 0; k <= 17; k++) begin
            step(1, 0, 0, 8'h30);
            chk("s1_locked", locked_q, k >= 9);
            chk("s1_en0", clk_en[0], k >= 9);
            chk("s1_en1", clk_en[1], (k >= 9) && ((k - 9) % 4 == 0));
        end

        // 2: short high run, one low, then high: lock 9 edges after second rise
        do_reset("s2_rst");
        for (int k = 0; k < 5; k++) step(1, 0, 0, 8'h30);
        step(0, 0, 0, 8'h30);
        for (int k = 0; k <= 10; k++) begin
            step(1, 0, 0, 8'h30);
            chk("s2_locked", locked_q, k >= 9);
        end
        chk("s2_lost", lost_cnt, 0);

        // 3: four losses with full relock between; counter saturates at 3
        for (int d = 1; d <= 4; d++) begin
            step(0, 0, 0, 8'h30);
            step(0, 0, 0, 8'h30);
            chk("s3_still_locked", locked_q, 1);
            step(0, 0, 0, 8'h30);
            chk("s3_unlocked", locked_q, 0);
            chk("s3_en_off", clk_en, 0);
            chk("s3_lost", lost_cnt, (d > 3) ? 3 : d);
            chk("s3_sticky", lost_sticky, 1);
            for (int k = 0; k < 12; k++) step(1, 0, 0, 8'h30);
        end

        // 4: resync with ch1 at phase 2
        for (int k = 0; k < 8; k++) begin
            if (m_e - last_fire[1] == 2) break;
            step(1, 0, 0, 8'h30);
        end
        step(1, 1, 0, 8'h30);
        chk("s4_resync_fire", clk_en[1], 1);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 8'h30);
            chk("s4_period", clk_en[1], (k % 4) == 3);
        end

        // 5: lower ch1 ratio below current phase, then to 0
        for (int k = 0; k < 8; k++) begin
            if (m_e - last_fire[1] == 2) break;
            step(1, 0, 0, 8'h30);
        end
        step(1, 0, 0, 8'h10);
        chk("s5_wrap", clk_en[1], 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 8'h10);
            chk("s5_period2", clk_en[1], (k % 2) == 1);
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 8'h00);
            chk("s5_const", clk_en[1], 1);
        end

        // 6: clr_lost coinciding with loss, clr_lost alone, reset during QUALIFY
        step(0, 0, 0, 8'h30);
        step(0, 0, 0, 8'h30);
        step(0, 0, 1, 8'h30);
        chk("s6_clr_loss_cnt", lost_cnt, 1);
        chk("s6_clr_loss_sticky", lost_sticky, 1);
        step(0, 0, 1, 8'h30);
        chk("s6_clr_cnt", lost_cnt, 0);
        chk("s6_clr_sticky", lost_sticky, 0);
        for (int k = 0; k < 12; k++) step(1, 0, 0, 8'h30);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h30);
        chk("s6_relost", lost_cnt, 1);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 8'h30);
        chk("s6_qualify", dbg_state, QUALIFY);
        do_reset("s6_rst");
        for (int k = 0; k <= 10; k++) begin
            step(1, 0, 0, 8'h30);
            chk("s6_reacq", locked_q, k >= 9);
        end

        // Randomized traffic against the model
        pl  = 1'b1;
        rem = 20;
        dv  = 8'h30;
        for (int k = 0; k < 600; k++) begin
            if (rem == 0) begin
                pl  = ~pl;
                rem = pl ? $urandom_range(1, 30) : $urandom_range(1, 4);
            end
            rem--;
            if ($urandom_range(0, 15) == 0) dv = 8'($urandom_range(0, 255));
            step(pl, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
